column_bypass_multiplier_param: RTL and testbench
=================================================

COLUMN_BYPASS_MULTIPLIER_PARAM -- requirements
Module: column_bypass_multiplier_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and result width in bits (legal 8..64).
REQ-002 The block SHALL have parameter RD_IDX_W, default 5, meaning destination-register tag width.
REQ-003 The block SHALL have port clk_i  input  1  clock; one clock, all state rising-edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port start_i  input  1  request; sampled only when accepting.
REQ-006 The block SHALL have port flush_i  input  1  abort current operation.
REQ-007 The block SHALL have port op_i  input  2  mode: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
REQ-008 The block SHALL have port op_a_i  input  WIDTH  multiplier, whose set bits set latency.
REQ-009 The block SHALL have port op_b_i  input  WIDTH  multiplicand.
REQ-010 The block SHALL have port rd_idx_i  input  RD_IDX_W  tag, returned with the result.
REQ-011 The block SHALL have port busy_o  output  1  high while an operation iterates.
REQ-012 The block SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-013 The block SHALL have port result_o  output  WIDTH  selected product half.
REQ-014 The block SHALL have port result_rd_idx_o  output  RD_IDX_W  tag of the completed operation.

Function
REQ-015 The block SHALL implement states IDLE, RUN and DONE; busy_o=1 only in RUN, done_o=1 only in DONE.
REQ-016 Acceptance SHALL occur on an edge with start_i=1, flush_i=0 and state IDLE or DONE (back-to-back allowed); start_i in RUN SHALL be ignored.
REQ-017 On acceptance the block SHALL latch magnitudes |a|, |b| (signed per mode: a signed for ops 1 and 2, b signed for op 1 only, else unsigned), the product sign, op_i and rd_idx_i, and clear a 2*WIDTH accumulator.
REQ-018 K SHALL be the number of set bits of |a|; if K>0 the next state SHALL be RUN, otherwise DONE.
REQ-019 Each RUN cycle SHALL add |b| shifted left by the index of the lowest remaining set bit of |a| into the accumulator and clear that bit; zero columns SHALL be bypassed at no cost.
REQ-020 RUN SHALL last exactly K cycles, then DONE for exactly one cycle, then IDLE unless a new start is accepted in DONE.
REQ-021 In DONE the 2*WIDTH product SHALL be two's-complement negated if the sign is 1; result_o SHALL be bits [WIDTH-1:0] for MUL, else bits [2*WIDTH-1:WIDTH].
REQ-022 The most-negative signed a (magnitude 2^(WIDTH-1)) SHALL be handled exactly, with K=1.
REQ-023 result_o and result_rd_idx_o SHALL update only when DONE is entered and hold until the next completion.
REQ-024 flush_i=1 SHALL force IDLE on the next edge from any state, suppressing done_o, leaving result_o unchanged; flush_i wins over a simultaneous start_i.

Reset
REQ-025 On rst_i=1 at an edge, the state SHALL become IDLE, with busy_o=0, done_o=0, result_o=0, result_rd_idx_o=0 and the accumulator cleared.
REQ-026 Reset mid-operation SHALL discard the operation without a done_o pulse; reset SHALL take priority over start_i and flush_i.

Configuration
REQ-027 With macro CBM_EARLY_ZERO_EN defined, acceptance with op_a_i=0 or op_b_i=0 SHALL go straight to DONE with result 0, with zero RUN cycles.
REQ-028 Without CBM_EARLY_ZERO_EN, latency SHALL be K RUN cycles regardless of op_b_i; results SHALL be identical in both builds.

Verification
REQ-029 The bench SHALL check: WIDTH=32, MUL, a=7, b=9 -> 3 busy cycles, then done_o with result_o=63 (0x3F).
REQ-030 The bench SHALL check: MULH, a=0x80000000, b=7 -> 1 busy cycle, result_o=0xFFFFFFFC.
REQ-031 The bench SHALL check: MULHU, a=0xFFFFFFFF, b=0xFFFFFFFF -> 32 busy cycles, result_o=0xFFFFFFFE; MUL of the same operands -> 0x00000001.
REQ-032 The bench SHALL check: MUL, a=0x0000F000, b=0 -> 4 busy cycles without CBM_EARLY_ZERO_EN and 0 with it, result_o=0 in both builds.
REQ-033 The bench SHALL check: start a=0xFF, b=3, rd_idx=5, then flush_i on the 3rd busy cycle -> no done_o, IDLE next cycle, result_o keeps its prior value; a start in the same cycle as flush_i is ignored.
REQ-034 The bench SHALL check: back-to-back starts (a=1,b=2,tag 1 in IDLE; a=3,b=4,tag 2 in DONE) -> done_o pulses give result 2 with tag 1, then result 12 with tag 2, with no idle gap between operations.

Source files
------------

// File: rtl/column_bypass_multiplier_param.sv
// Iterative multiplier that adds only the non-zero columns of |a| (one set bit per cycle).
// Optional build macro CBM_EARLY_ZERO_EN: a zero operand at acceptance skips RUN entirely.
module column_bypass_multiplier_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned RD_IDX_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                flush_i,
  input  logic [1:0]          op_i,
  input  logic [WIDTH-1:0]    op_a_i,
  input  logic [WIDTH-1:0]    op_b_i,
  input  logic [RD_IDX_W-1:0] rd_idx_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [WIDTH-1:0]    result_o,
  output logic [RD_IDX_W-1:0] result_rd_idx_o
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned IdxW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              r_state;
  logic [WIDTH-1:0]    r_mag_a;
  logic [WIDTH-1:0]    r_mag_b;
  logic                r_sign;
  logic [1:0]          r_op;
  logic [RD_IDX_W-1:0] r_rd_idx;
  logic [PW-1:0]       r_acc;
  logic [WIDTH-1:0]    r_result;
  logic [RD_IDX_W-1:0] r_result_rd_idx;

  logic                w_accept_state;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [WIDTH-1:0]    w_mag_a;
  logic [WIDTH-1:0]    w_mag_b;
  logic                w_skip_run;
  logic [WIDTH-1:0]    w_lowest;
  logic [WIDTH-1:0]    w_mag_a_next;
  logic [IdxW-1:0]     w_idx;
  logic [PW-1:0]       w_addend;
  logic [PW-1:0]       w_acc_sum;
  logic [PW-1:0]       w_prod;
  logic [WIDTH-1:0]    w_res;
  logic                w_last;

  assign w_accept_state = (r_state == StIdle) || (r_state == StDone);

  // a is signed for MULH/MULHSU, b only for MULH
  assign w_a_neg = ((op_i == 2'd1) || (op_i == 2'd2)) && op_a_i[WIDTH-1];
  assign w_b_neg = (op_i == 2'd1) && op_b_i[WIDTH-1];
  assign w_mag_a = w_a_neg ? -op_a_i : op_a_i;
  assign w_mag_b = w_b_neg ? -op_b_i : op_b_i;

`ifdef CBM_EARLY_ZERO_EN
  assign w_skip_run = (op_a_i == '0) || (op_b_i == '0);
`else
  assign w_skip_run = (w_mag_a == '0);
`endif

  assign w_lowest     = r_mag_a & -r_mag_a;
  assign w_mag_a_next = r_mag_a & ~w_lowest;
  assign w_last       = (w_mag_a_next == '0);

  always_comb begin
    w_idx = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (r_mag_a[i]) w_idx = IdxW'(i);
    end
  end

  assign w_addend  = PW'(r_mag_b) << w_idx;
  assign w_acc_sum = r_acc + w_addend;
  assign w_prod    = r_sign ? -w_acc_sum : w_acc_sum;
  assign w_res     = (r_op == 2'd0) ? w_prod[WIDTH-1:0] : w_prod[PW-1:WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= StIdle;
      r_mag_a         <= '0;
      r_mag_b         <= '0;
      r_sign          <= 1'b0;
      r_op            <= 2'd0;
      r_rd_idx        <= '0;
      r_acc           <= '0;
      r_result        <= '0;
      r_result_rd_idx <= '0;
    end else if (flush_i) begin
      r_state <= StIdle;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start_i && w_accept_state) begin
            r_mag_a  <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_sign   <= w_a_neg ^ w_b_neg;
            r_op     <= op_i;
            r_rd_idx <= rd_idx_i;
            r_acc    <= '0;
            if (w_skip_run) begin
              // Product is zero, so the sign cannot matter
              r_state         <= StDone;
              r_result        <= '0;
              r_result_rd_idx <= rd_idx_i;
            end else begin
              r_state <= StRun;
            end
          end else begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          r_acc   <= w_acc_sum;
          r_mag_a <= w_mag_a_next;
          if (w_last) begin
            r_state         <= StDone;
            r_result        <= w_res;
            r_result_rd_idx <= r_rd_idx;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy_o          = (r_state == StRun);
  assign done_o          = (r_state == StDone);
  assign result_o        = r_result;
  assign result_rd_idx_o = r_result_rd_idx;

endmodule

// File: tb/tb_column_bypass_multiplier_param.sv
// Scoreboard bench: stimulus pushes expected {result, tag, busy cycles}; a negedge monitor pops.
module tb_column_bypass_multiplier_param;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        flush_i;
  logic [1:0]  op_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [4:0]  rd_idx_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  result_rd_idx_o;

  always #5 clk_i = ~clk_i;

  column_bypass_multiplier_param #(
    .WIDTH   (32),
    .RD_IDX_W(5)
  ) u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .flush_i        (flush_i),
    .op_i           (op_i),
    .op_a_i         (op_a_i),
    .op_b_i         (op_b_i),
    .rd_idx_i       (rd_idx_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .result_o       (result_o),
    .result_rd_idx_o(result_rd_idx_o)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          busy;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   busy_cnt = 0;

`ifdef CBM_EARLY_ZERO_EN
  localparam int ZeroBBusy = 0;
`else
  localparam int ZeroBBusy = 4;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: counts busy cycles preceding each done pulse and checks against the scoreboard
  always @(negedge clk_i) begin
    if (rst_i) begin
      busy_cnt = 0;
    end else if (busy_o) begin
      busy_cnt++;
      if (done_o) chk("busy_done_overlap", 64'(done_o), 64'd0);
    end else begin
      if (done_o) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got result 0x%0h tag %0d expected no done", result_o,
                   result_rd_idx_o);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", 64'(result_o), 64'(e.res));
          chk("tag", 64'(result_rd_idx_o), 64'(e.tag));
          chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
        end
      end
      busy_cnt = 0;
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!done_o) chk("done_timeout", 64'd0, 64'd1);
  endtask

  // b2b=1 issues at the current negedge (expected to be a DONE cycle), else after one idle cycle
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] res, input int busy,
                        input bit b2b);
    exp_t e;
    if (!b2b) @(negedge clk_i);
    e.res = res;
    e.tag = tag;
    e.busy = busy;
    q.push_back(e);
    op_i = op;
    op_a_i = a;
    op_b_i = b;
    rd_idx_i = tag;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    @(negedge clk_i);
    wait_done();
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i = 2'd0;
    op_a_i = '0;
    op_b_i = '0;
    rd_idx_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_tag", 64'(result_rd_idx_o), 64'd0);

    run_op(2'd0, 32'd7, 32'd9, 5'd3, 32'h0000_003F, 3, 1'b0);
    run_op(2'd1, 32'h8000_0000, 32'd7, 5'd1, 32'hFFFF_FFFC, 1, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 5'd2, 32'h0000_0000, 2, 1'b0);
    run_op(2'd2, 32'hFFFF_FFFF, 32'd2, 5'd6, 32'hFFFF_FFFF, 1, 1'b0);
    run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 32, 1'b0);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001, 32, 1'b0);

    // Flush on the 3rd busy cycle, with a competing start that must be ignored
    @(negedge clk_i);
    op_i = 2'd0;
    op_a_i = 32'hFF;
    op_b_i = 32'd3;
    rd_idx_i = 5'd5;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    start_i = 1'b1;
    op_a_i = 32'd1;
    op_b_i = 32'd1;
    rd_idx_i = 5'd9;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("flush_busy", 64'(busy_o), 64'd0);
    chk("flush_done", 64'(done_o), 64'd0);
    chk("flush_result_held", 64'(result_o), 64'd1);
    chk("flush_tag_held", 64'(result_rd_idx_o), 64'd4);
    @(negedge clk_i);
    chk("flush_still_idle", 64'({busy_o, done_o}), 64'd0);

    run_op(2'd0, 32'h0000_F000, 32'd0, 5'd8, 32'h0, ZeroBBusy, 1'b0);

    run_op(2'd0, 32'd1, 32'd2, 5'd1, 32'd2, 1, 1'b0);
    run_op(2'd0, 32'd3, 32'd4, 5'd2, 32'd12, 2, 1'b1);

    // Reset mid-operation, asserted together with start: no done, outputs cleared
    @(negedge clk_i);
    op_a_i = 32'hFF;
    op_b_i = 32'd5;
    rd_idx_i = 5'd11;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_done", 64'(done_o), 64'd0);
    chk("midrst_result", 64'(result_o), 64'd0);
    chk("midrst_tag", 64'(result_rd_idx_o), 64'd0);

    repeat (5) @(negedge clk_i);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
